trig_capture_ctrl: RTL and testbench

Capture sequencer for the logic-analyzer trigger path; it drives the trigger delay line and the sample memory.
- Arms the trigger, waits out a holdoff, and accepts the first qualified trigger edge.
- Counts a programmable number of post-trigger samples while generating write enables and addresses for the sample memory.
- Owns the 10-bit trigger-delay register, loaded by byte writes from the host interface, and emits the load strobe consumed by the delay line.

---
 rtl/trig_capture_ctrl.sv | 169 ++++++++++++++++
 tb/tb_trig_capture_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_capture_ctrl.sv
// Logic-analyzer capture sequencer: arm, holdoff, trigger, post-trigger fill.
// Define TRIG_CAPTURE_PRETRIG_EN to add the pre_count minimum-fill qualifier.
module trig_capture_ctrl #(
    parameter int AW     = 10,
    parameter int HOLD_W = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              start,
    input  logic              abort,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic [AW-1:0]     post_count,
    input  logic              trig_in,
    input  logic [7:0]        cfg_data,
    input  logic              cfg_wr,
    input  logic              cfg_sel,
`ifdef TRIG_CAPTURE_PRETRIG_EN
    input  logic [AW-1:0]     pre_count,
`endif
    output logic              en_trig,
    output logic [9:0]        delay_val,
    output logic              delay_ld,
    output logic              sample_en,
    output logic [AW-1:0]     wr_addr,
    output logic [AW-1:0]     trig_addr,
    output logic              trig_seen,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        WAIT,
        POST,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_n;
    logic [AW-1:0]     post_cnt;
    logic [AW-1:0]     post_n;
    logic              trig_q;
    logic              act;
    logic              arm;
    logic              accept;
    logic              pre_ok;

`ifdef TRIG_CAPTURE_PRETRIG_EN
    logic [AW-1:0] pre_cnt;

    // Saturating count of samples written since arming
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre_cnt <= '0;
        end else if (arm) begin
            pre_cnt <= '0;
        end else if (act && (pre_cnt != '1)) begin
            pre_cnt <= pre_cnt + AW'(1);
        end
    end

    assign pre_ok = (pre_cnt >= pre_count);
`else
    assign pre_ok = 1'b1;
`endif

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        post_n  = post_cnt;
        arm     = 1'b0;
        accept  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = HOLD;
                    hold_n  = holdoff;
                    arm     = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_n = WAIT;
                end else begin
                    hold_n = hold_cnt - HOLD_W'(1);
                end
            end
            WAIT: begin
                if (trig_in && !trig_q && pre_ok) begin
                    state_n = POST;
                    post_n  = post_count;
                    accept  = 1'b1;
                end
            end
            POST: begin
                // post_count of 0 wraps through 2^AW samples
                post_n = post_cnt - AW'(1);
                if (post_cnt == AW'(1)) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            arm     = 1'b0;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            post_cnt  <= '0;
            trig_q    <= 1'b0;
            act       <= 1'b0;
            en_trig   <= 1'b0;
            done      <= 1'b0;
            trig_seen <= 1'b0;
            wr_addr   <= '0;
            trig_addr <= '0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            post_cnt  <= post_n;
            trig_q    <= trig_in;
            act       <= (state_n == HOLD) ||
                         (state_n == WAIT) ||
                         (state_n == POST);
            en_trig   <= (state_n == WAIT) ||
                         (state_n == POST);
            done      <= (state_n == DONE);
            trig_seen <= accept;
            if (arm) begin
                wr_addr <= '0;
            end else if (act) begin
                wr_addr <= wr_addr + AW'(1);
            end
            if (accept) begin
                trig_addr <= wr_addr;
            end
        end
    end

    assign sample_en = act;
    assign busy      = act;

    // Power-up value matches the delay line's own reset setting
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            delay_val <= 10'd100;
            delay_ld  <= 1'b0;
        end else begin
            delay_ld <= cfg_wr && cfg_sel;
            if (cfg_wr) begin
                if (cfg_sel) begin
                    delay_val[1:0] <= cfg_data[1:0];
                end else begin
                    delay_val[9:2] <= cfg_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Scoreboard bench for trig_capture_ctrl (AW=4): directed captures,
// trigger/done/delay_ld events matched against hand-computed expectations.
module tb_trig_capture_ctrl;

    localparam int AW = 4;
    localparam int HW = 4;
    localparam int K_TRIG = 0;
    localparam int K_DONE = 1;
    localparam int K_DLD  = 2;

    logic          CLK;
    logic          RSTn;
    logic          start;
    logic          abort;
    logic [HW-1:0] holdoff;
    logic [AW-1:0] post_count;
    logic          trig_in;
    logic [7:0]    cfg_data;
    logic          cfg_wr;
    logic          cfg_sel;
`ifdef TRIG_CAPTURE_PRETRIG_EN
    logic [AW-1:0] pre_count;
`endif
    logic          en_trig;
    logic [9:0]    delay_val;
    logic          delay_ld;
    logic          sample_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] trig_addr;
    logic          trig_seen;
    logic          busy;
    logic          done;

    trig_capture_ctrl #(.AW(AW), .HOLD_W(HW)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .start      (start),
        .abort      (abort),
        .holdoff    (holdoff),
        .post_count (post_count),
        .trig_in    (trig_in),
        .cfg_data   (cfg_data),
        .cfg_wr     (cfg_wr),
        .cfg_sel    (cfg_sel),
`ifdef TRIG_CAPTURE_PRETRIG_EN
        .pre_count  (pre_count),
`endif
        .en_trig    (en_trig),
        .delay_val  (delay_val),
        .delay_ld   (delay_ld),
        .sample_en  (sample_en),
        .wr_addr    (wr_addr),
        .trig_addr  (trig_addr),
        .trig_seen  (trig_seen),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic string kname(input int k);
        if (k == K_TRIG) return "trig_seen";
        if (k == K_DONE) return "done";
        return "delay_ld";
    endfunction

    task automatic expect_ev(input int k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got(input int k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected: cyc=%0d val=%0d, required none",
                     kname(k), cyc, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val != v) begin
                errors++;
                $display("FAIL %s event: got %s cyc=%0d val=%0d, required %s cyc=%0d val=%0d",
                         kname(e.kind), kname(k), cyc, v,
                         kname(e.kind), e.cyc, e.val);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: post-trigger sample count reported with the done event
    initial begin
        logic done_q;
        int   post_n;
        done_q = 1'b0;
        post_n = 0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                done_q = 1'b0;
                post_n = 0;
            end else begin
                if (trig_seen) post_n = 1;
                else if (sample_en) post_n++;
                if (trig_seen) got(K_TRIG, int'(trig_addr));
                if (done && !done_q) got(K_DONE, post_n);
                if (delay_ld) got(K_DLD, int'(delay_val));
                done_q = done;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        RSTn       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        holdoff    = '0;
        post_count = '0;
        trig_in    = 1'b0;
        cfg_wr     = 1'b1;
        cfg_sel    = 1'b1;
        cfg_data   = 8'hFF;
`ifdef TRIG_CAPTURE_PRETRIG_EN
        pre_count  = '0;
`endif
        tick(3);
        cfg_wr = 1'b0;
        tick(1);
        #2 RSTn = 1'b1;
        #1;
        chk("rst en_trig", en_trig, 0);
        chk("rst sample_en", sample_en, 0);
        chk("rst trig_seen", trig_seen, 0);
        chk("rst delay_ld", delay_ld, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst trig_addr", trig_addr, 0);
        chk("rst delay_val", delay_val, 100);

        // Delay register byte writes
        tick(1);
        s = cyc;
        cfg_wr   = 1'b1;
        cfg_sel  = 1'b0;
        cfg_data = 8'h3A;
        tick(1);
        chk("delay hi byte", delay_val, 'h0E8);
        cfg_sel  = 1'b1;
        cfg_data = 8'h02;
        expect_ev(K_DLD, s + 2, 'h0EA);
        tick(1);
        cfg_wr = 1'b0;
        chk("delay full", delay_val, 'h0EA);
        tick(2);

        // holdoff=3, edge at 2nd WAIT cycle, post_count=5
        s = cyc;
        holdoff    = 4'd3;
        post_count = 4'd5;
        start      = 1'b1;
        expect_ev(K_TRIG, s + 7, 5);
        expect_ev(K_DONE, s + 12, 5);
        tick(1);
        start = 1'b0;
        chk("arm busy", busy, 1);
        chk("arm sample_en", sample_en, 1);
        chk("arm wr_addr", wr_addr, 0);
        tick(3);
        chk("hold en_trig", en_trig, 0);
        tick(1);
        chk("wait en_trig", en_trig, 1);
        tick(1);
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0;
        tick(5);
        chk("done level", done, 1);
        chk("done sample_en", sample_en, 0);
        chk("done busy", busy, 0);
        tick(1);

        // post_count=0: 16 samples, address wrap; start in WAIT ignored
        s = cyc;
        holdoff    = 4'd0;
        post_count = 4'd0;
        start      = 1'b1;
        expect_ev(K_TRIG, s + 4, 2);
        expect_ev(K_DONE, s + 20, 16);
        tick(1);
        start = 1'b0;
        tick(1);
        chk("wrap en_trig", en_trig, 1);
        start = 1'b1;
        tick(1);
        start   = 1'b0;
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0;
        tick(12);
        chk("wrap addr 15", wr_addr, 15);
        tick(1);
        chk("wrap addr 0", wr_addr, 0);
        chk("wrap trig_addr", trig_addr, 2);
        tick(3);
        chk("wrap done", done, 1);
        tick(1);

        // trig_in high from arming: only a fresh rise is accepted
        s = cyc;
        holdoff    = 4'd1;
        post_count = 4'd2;
        trig_in    = 1'b1;
        start      = 1'b1;
        expect_ev(K_TRIG, s + 9, 7);
        expect_ev(K_DONE, s + 11, 2);
        tick(1);
        start = 1'b0;
        tick(5);
        trig_in = 1'b0;
        tick(2);
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0;
        tick(2);
        chk("level done", done, 1);
        tick(1);

        // abort in POST, then start+abort together
        s = cyc;
        holdoff    = 4'd0;
        post_count = 4'd10;
        start      = 1'b1;
        expect_ev(K_TRIG, s + 4, 2);
        tick(1);
        start = 1'b0;
        tick(2);
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0;
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort sample_en", sample_en, 0);
        chk("abort en_trig", en_trig, 0);
        chk("abort done", done, 0);
        chk("abort trig_addr", trig_addr, 2);
        chk("abort delay_val", delay_val, 'h0EA);
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", busy, 0);
        chk("start+abort sample_en", sample_en, 0);
        tick(2);

`ifdef TRIG_CAPTURE_PRETRIG_EN
        // pre_count=8: edge at sample 4 ignored, at sample 9 accepted
        s = cyc;
        pre_count  = 4'd8;
        holdoff    = 4'd0;
        post_count = 4'd1;
        start      = 1'b1;
        expect_ev(K_TRIG, s + 11, 9);
        expect_ev(K_DONE, s + 12, 1);
        tick(1);
        start = 1'b0;
        tick(4);
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0;
        tick(4);
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0;
        tick(1);
        chk("pretrig done", done, 1);
        pre_count = '0;
        tick(1);
`endif

        // Reset mid-capture returns everything to power-up values
        s = cyc;
        holdoff    = 4'd0;
        post_count = 4'd5;
        start      = 1'b1;
        expect_ev(K_TRIG, s + 4, 2);
        tick(1);
        start = 1'b0;
        tick(2);
        trig_in = 1'b1;
        tick(1);
        trig_in  = 1'b0;
        cfg_wr   = 1'b1;
        cfg_sel  = 1'b1;
        cfg_data = 8'h01;
        #2 RSTn = 1'b0;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst sample_en", sample_en, 0);
        chk("mid rst trig_addr", trig_addr, 0);
        chk("mid rst wr_addr", wr_addr, 0);
        chk("mid rst delay_val", delay_val, 100);
        chk("mid rst delay_ld", delay_ld, 0);
        tick(1);
        cfg_wr = 1'b0;
        tick(1);
        #2 RSTn = 1'b1;
        tick(3);
        chk("post rst delay_val", delay_val, 100);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending, required 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
